// File: rtl/snake_speed_ctrl.sv
// Snake game-speed controller: owns the speed level, sequences IDLE/RUN/PAUSE/OVER
// and emits a one-cycle move tick whose period shrinks as the speed rises.
//   state    | meaning
//   ST_IDLE  | waiting for start; manual speed adjust allowed
//   ST_RUN   | game active; move ticks and apple-driven speed-ups
//   ST_PAUSE | counters frozen, no ticks
//   ST_OVER  | final speed held for display until restart
module snake_speed_ctrl #(
    parameter int TICK_BASE        = 50_000_000,
    parameter int TICK_STEP        = 2_000_000,
    parameter int SPEED_MIN        = 1,
    parameter int SPEED_MAX        = 20,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int CNT_W            = 26
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_game_over,
    input  logic       i_apple,
    input  logic       i_speed_up,
    input  logic       i_speed_down,
    output logic [4:0] o_speed,
    output logic       o_move_tick,
    output logic       o_running,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // One spare bit keeps the period subtraction clear of the counter width.
    localparam int PW = CNT_W + 1;
    localparam int AW = $clog2(APPLES_PER_LEVEL + 1);

    localparam logic [4:0]    SPD_MIN = 5'(SPEED_MIN);
    localparam logic [4:0]    SPD_MAX = 5'(SPEED_MAX);
    localparam logic [PW-1:0] P_BASE  = PW'(TICK_BASE);
    localparam logic [PW-1:0] P_STEP  = PW'(TICK_STEP);
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [AW-1:0] APL     = AW'(APPLES_PER_LEVEL);

    state_t           r_state;
    logic [4:0]       r_speed;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [AW-1:0]    r_apple_cnt;
    logic             r_move_tick;

    state_t           w_state_nxt;
    logic [4:0]       w_speed_nxt;
    logic [CNT_W-1:0] w_tick_cnt_nxt;
    logic [AW-1:0]    w_apple_cnt_nxt;
    logic             w_move_tick_nxt;

    logic [PW-1:0]    w_period;
    logic             w_tick_due;
    logic [4:0]       w_speed_inc;
    logic [4:0]       w_speed_dec;
    logic [AW-1:0]    w_apple_inc;

    assign w_period    = P_BASE - (PW'(r_speed) - P_ONE) * P_STEP;
    // >= rather than == so a period that shrank mid-count still fires.
    assign w_tick_due  = {1'b0, r_tick_cnt} >= (w_period - P_ONE);
    assign w_speed_inc = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 5'd1;
    assign w_speed_dec = (r_speed <= SPD_MIN) ? SPD_MIN : r_speed - 5'd1;
    assign w_apple_inc = r_apple_cnt + AW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_speed_nxt     = r_speed;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_apple_cnt_nxt = r_apple_cnt;
        w_move_tick_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = ST_RUN;
                    w_tick_cnt_nxt  = '0;
                    w_apple_cnt_nxt = '0;
                end else if (i_speed_up && !i_speed_down) begin
                    w_speed_nxt = w_speed_inc;
                end else if (i_speed_down && !i_speed_up) begin
                    w_speed_nxt = w_speed_dec;
                end
            end
            ST_RUN: begin
                if (i_game_over) begin
                    w_state_nxt = ST_OVER;
                end else if (i_pause) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    if (w_tick_due) begin
                        w_move_tick_nxt = 1'b1;
                        w_tick_cnt_nxt  = '0;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
                    end
                    if (i_apple) begin
                        if (w_apple_inc == APL) begin
                            w_apple_cnt_nxt = '0;
                            w_speed_nxt     = w_speed_inc;
                        end else begin
                            w_apple_cnt_nxt = w_apple_inc;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (i_game_over) begin
                    w_state_nxt = ST_OVER;
                end else if (i_pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_OVER: begin
                if (i_start) begin
                    w_state_nxt     = ST_IDLE;
                    w_speed_nxt     = SPD_MIN;
                    w_tick_cnt_nxt  = '0;
                    w_apple_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_speed     <= SPD_MIN;
            r_tick_cnt  <= '0;
            r_apple_cnt <= '0;
            r_move_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_speed     <= w_speed_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_apple_cnt <= w_apple_cnt_nxt;
            r_move_tick <= w_move_tick_nxt;
        end
    end

    assign o_speed     = r_speed;
    assign o_move_tick = r_move_tick;
    assign o_running   = (r_state == ST_RUN);
    assign o_state     = r_state;

endmodule

// File: tb/tb_snake_speed_ctrl.sv
// Bench for snake_speed_ctrl: directed test-plan steps followed by random pulses,
// every cycle compared against a behavioural model of the game rules.
module tb_snake_speed_ctrl;

    localparam int TB   = 10;
    localparam int TS   = 2;
    localparam int SMIN = 1;
    localparam int SMAX = 4;
    localparam int APL  = 2;
    localparam int CW   = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, go = 1'b0, apple = 1'b0, up = 1'b0, dn = 1'b0;
    logic [4:0] speed;
    logic       tick, running;
    logic [1:0] state;

    always #5 clk = ~clk;

    snake_speed_ctrl #(
        .TICK_BASE(TB), .TICK_STEP(TS), .SPEED_MIN(SMIN), .SPEED_MAX(SMAX),
        .APPLES_PER_LEVEL(APL), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause),
        .i_game_over(go), .i_apple(apple), .i_speed_up(up), .i_speed_down(dn),
        .o_speed(speed), .o_move_tick(tick), .o_running(running), .o_state(state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: run cycles since the last tick; a tick fires on the P-th run cycle.
    int m_state   = S_IDLE;
    int m_speed   = SMIN;
    int m_elapsed = 0;
    int m_apples  = 0;
    bit m_tick    = 1'b0;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endfunction

    function automatic int period_of(int s);
        return TB - (s - 1) * TS;
    endfunction

    function automatic void model_step();
        m_tick = 1'b0;
        if (!rst_n) begin
            m_state = S_IDLE; m_speed = SMIN; m_elapsed = 0; m_apples = 0;
        end else begin
            case (m_state)
                S_IDLE: begin
                    if (start) begin
                        m_state = S_RUN; m_elapsed = 0; m_apples = 0;
                    end else if (up && !dn) begin
                        m_speed = (m_speed < SMAX) ? m_speed + 1 : SMAX;
                    end else if (dn && !up) begin
                        m_speed = (m_speed > SMIN) ? m_speed - 1 : SMIN;
                    end
                end
                S_RUN: begin
                    if (go) m_state = S_OVER;
                    else if (pause) m_state = S_PAUSE;
                    else begin
                        m_elapsed++;
                        if (m_elapsed >= period_of(m_speed)) begin
                            m_tick = 1'b1; m_elapsed = 0;
                        end
                        if (apple) begin
                            m_apples = (m_apples + 1) % APL;
                            if (m_apples == 0) m_speed = (m_speed < SMAX) ? m_speed + 1 : SMAX;
                        end
                    end
                end
                S_PAUSE: begin
                    if (go) m_state = S_OVER;
                    else if (pause) m_state = S_RUN;
                end
                default: begin
                    if (start) begin
                        m_state = S_IDLE; m_speed = SMIN; m_elapsed = 0; m_apples = 0;
                    end
                end
            endcase
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state), m_state);
        chk("speed", 32'(speed), m_speed);
        chk("tick", 32'(tick), 32'(m_tick));
        chk("running", 32'(running), 32'(m_state == S_RUN));
        start = 1'b0; pause = 1'b0; go = 1'b0; apple = 1'b0; up = 1'b0; dn = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if (tick === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (tick === 1'b1) cnt++;
        end
    endtask

    int k;
    int nt;

    initial begin
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_speed", 32'(speed), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_running", 32'(running), 0);
        rst_n = 1'b1;
        cyc();

        // start and base period
        start = 1'b1; cyc();
        chk("t1_state", 32'(state), 1);
        chk("t1_running", 32'(running), 1);
        chk("t1_speed", 32'(speed), 1);
        wait_tick(20, k); chk("t1_first_tick", k, 10);
        wait_tick(20, k); chk("t1_period", k, 10);

        // apple-driven speed-up and saturation
        apple = 1'b1; cyc();
        apple = 1'b1; cyc();
        chk("t2_speed2", 32'(speed), 2);
        wait_tick(20, k);
        wait_tick(20, k); chk("t2_period8", k, 8);
        repeat (6) begin apple = 1'b1; cyc(); end
        chk("t2_speed4", 32'(speed), 4);
        wait_tick(20, k);
        wait_tick(20, k); chk("t2_period4", k, 4);
        repeat (4) begin apple = 1'b1; cyc(); end
        chk("t2_speed_sat", 32'(speed), 4);

        // pause / resume keeps the count
        go = 1'b1; cyc();
        start = 1'b1; cyc();
        chk("t3_idle_speed", 32'(speed), 1);
        start = 1'b1; cyc();
        wait_tick(20, k); chk("t3_first_tick", k, 10);
        repeat (4) cyc();
        pause = 1'b1; cyc();
        chk("t3_paused", 32'(state), 2);
        count_ticks(20, nt); chk("t3_no_tick", nt, 0);
        chk("t3_still_paused", 32'(state), 2);
        pause = 1'b1; cyc();
        chk("t3_resumed", 32'(state), 1);
        wait_tick(20, k); chk("t3_resume_tick", k, 6);

        // game_over beats pause
        repeat (4) begin apple = 1'b1; cyc(); end
        chk("t4_speed3", 32'(speed), 3);
        go = 1'b1; pause = 1'b1; cyc();
        chk("t4_over", 32'(state), 3);
        count_ticks(15, nt); chk("t4_no_tick", nt, 0);
        chk("t4_speed_hold", 32'(speed), 3);
        start = 1'b1; cyc();
        chk("t4_idle", 32'(state), 0);
        chk("t4_speed_min", 32'(speed), 1);

        // manual speed adjust
        repeat (5) begin up = 1'b1; cyc(); end
        chk("t5_up_sat", 32'(speed), 4);
        up = 1'b1; dn = 1'b1; cyc();
        chk("t5_both", 32'(speed), 4);
        repeat (5) begin dn = 1'b1; cyc(); end
        chk("t5_dn_sat", 32'(speed), 1);
        start = 1'b1; cyc();
        up = 1'b1; cyc();
        up = 1'b1; cyc();
        dn = 1'b1; cyc();
        chk("t5_run_ignore", 32'(speed), 1);

        // reset mid-run wins over an apple
        repeat (4) begin apple = 1'b1; cyc(); end
        chk("t6_speed3", 32'(speed), 3);
        rst_n = 1'b0; apple = 1'b1; cyc();
        chk("t6_state", 32'(state), 0);
        chk("t6_speed", 32'(speed), 1);
        chk("t6_tick", 32'(tick), 0);
        rst_n = 1'b1; cyc();
        start = 1'b1; cyc();
        wait_tick(20, k); chk("t6_first_tick", k, 10);

        // random pulses against the model
        repeat (3000) begin
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 99) < 3);
            pause = ($urandom_range(0, 99) < 3);
            go    = ($urandom_range(0, 99) < 1);
            apple = ($urandom_range(0, 99) < 12);
            up    = ($urandom_range(0, 99) < 10);
            dn    = ($urandom_range(0, 99) < 10);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
